fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised program-counter/fetch sequencer for the core: owns the PC, the jump-target LUT
//  and the start/done handshake. Supersedes the fixed 10-bit PC + 4-bit LUT pair: widths and
//  depth are parameters, the LUT is writable at run time, and there are stall and halt controls.
//  Sits between control/decoder (jump, halt, stall requests) and instr_ROM (prog_ctr).
// PARAMETERS
//  PC_W        10   PC / instruction-address width
//  LUT_AW      4    LUT pointer width; LUT depth = 2**LUT_AW
//  START_ADDR  0    PC value loaded on start
//  CNT_W       16   cycle-counter width (only with FETCH_CYCLE_CNT_EN)
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  start        in   1        level; begins a program run from IDLE or DONE
//  stall        in   1        freeze PC this cycle (memory/multicycle op busy)
//  halt         in   1        decoded halt instruction at current PC
//  jmp_en       in   1        take a jump this cycle
//  jmp_abs      in   1        1: target = lut[lut_ptr]; 0: PC-relative
//  lut_ptr      in   LUT_AW   LUT index for absolute jumps
//  rel_off      in   PC_W     two's-complement relative offset
//  lut_wr_en    in   1        LUT write strobe
//  lut_wr_addr  in   LUT_AW   LUT write index
//  lut_wr_data  in   PC_W     LUT write data
//  prog_ctr     out  PC_W     address to instr_ROM
//  fetch_valid  out  1        prog_ctr is a live fetch this cycle
//  busy         out  1        state == RUN
//  done         out  1        state == DONE
//  cycle_cnt    out  CNT_W    RUN cycles since last start (FETCH_CYCLE_CNT_EN only)
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, prog_ctr=START_ADDR, all LUT entries=0,
//   fetch_valid=busy=done=0, cycle_cnt=0.
//  FSM: IDLE --start--> RUN; RUN --halt & !stall--> DONE; DONE --start--> RUN; no other arcs.
//   Entering RUN loads prog_ctr=START_ADDR on the same edge; first fetch is the next cycle.
//   start is ignored while in RUN.
//  RUN, per edge, priority: stall > halt > jump > increment:
//   stall: prog_ctr holds; halt/jmp_en ignored.
//   halt: -> DONE; prog_ctr holds (points at the halt instruction).
//   jmp_en & jmp_abs: prog_ctr <= lut[lut_ptr].
//   jmp_en & !jmp_abs: prog_ctr <= prog_ctr + rel_off, modulo 2**PC_W.
//   otherwise: prog_ctr <= prog_ctr + 1; 2**PC_W-1 wraps to 0 without a flag.
//  fetch_valid = busy & !stall (combinational). done/busy are registered state decodes.
//  LUT: synchronous write in any state; a same-cycle read of the entry being written returns
//   the OLD value (read-before-write). Writes with lut_wr_en=0 are ignored.
//  Reset mid-run: immediate return to IDLE; LUT contents are lost.
// CONFIGURATION
//  FETCH_CYCLE_CNT_EN defined: cycle_cnt is present. It clears to 0 on the IDLE/DONE->RUN
//   edge and increments on each RUN edge (stalled or not), saturating at 2**CNT_W-1. It holds
//   in DONE.
//  Not defined: the cycle_cnt port and counter are absent. No other behaviour changes.
// STRUCTURE
//  fetch_pkg: typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_DONE} fetch_state_t; default
//   width constants PC_W_DEF=10 and LUT_AW_DEF=4, shared with control/top.
//  Sub-module jump_lut (#(LUT_AW, PC_W)): 2**LUT_AW x PC_W register array with async-low
//   clear, one write port and one combinational read port. The FSM and PC stay in fetch_unit.
// TESTING
//  1 Reset then start=1 for 1 cycle -> prog_ctr=0 on the next cycle, then 1,2,3; busy=1,
//    fetch_valid=1.
//  2 Write lut[3]=10'h1F0, then jmp_en=1, jmp_abs=1, lut_ptr=3 at PC 5 -> PC 0x1F0 next;
//    writing and jumping to lut[3] in the same cycle -> old value used.
//  3 PC=2, jmp_en=1, jmp_abs=0, rel_off=-3 (10'h3FD) -> PC 0x3FF; next increment -> 0x000.
//  4 stall=1 together with jmp_en and halt for 2 cycles -> PC held, fetch_valid=0,
//    state stays RUN.
//  5 halt=1 at PC 7 -> done=1 next cycle, PC stays 7; start=1 -> PC 0, busy=1, done=0;
//    start asserted during RUN has no effect.
//  6 With FETCH_CYCLE_CNT_EN, CNT_W=4: run 20 cycles -> cycle_cnt saturates at 15; restart
//    -> 0. Assert reset mid-run -> IDLE, LUT cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer and its neighbours.
package fetch_pkg;

   typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_DONE} fetch_state_t;

   localparam int PC_W_DEF   = 10;
   localparam int LUT_AW_DEF = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake/bus bundle between control/decoder (master) and fetch_unit (slave).
// cycle_cnt and CNT_W exist only when FETCH_CYCLE_CNT_EN is defined.
interface fetch_unit_if import fetch_pkg::*; #(
   parameter int PC_W   = PC_W_DEF,
   parameter int LUT_AW = LUT_AW_DEF
`ifdef FETCH_CYCLE_CNT_EN
   ,parameter int CNT_W = 16
`endif
);

   logic              start;
   logic              stall;
   logic              halt;
   logic              jmp_en;
   logic              jmp_abs;
   logic [LUT_AW-1:0] lut_ptr;
   logic [PC_W-1:0]   rel_off;
   logic              lut_wr_en;
   logic [LUT_AW-1:0] lut_wr_addr;
   logic [PC_W-1:0]   lut_wr_data;
   logic [PC_W-1:0]   prog_ctr;
   logic              fetch_valid;
   logic              busy;
   logic              done;
`ifdef FETCH_CYCLE_CNT_EN
   logic [CNT_W-1:0]  cycle_cnt;
`endif

   modport master (
      output start, stall, halt, jmp_en, jmp_abs, lut_ptr, rel_off,
             lut_wr_en, lut_wr_addr, lut_wr_data,
      input  prog_ctr, fetch_valid, busy, done
`ifdef FETCH_CYCLE_CNT_EN
      ,input cycle_cnt
`endif
   );

   modport slave (
      input  start, stall, halt, jmp_en, jmp_abs, lut_ptr, rel_off,
             lut_wr_en, lut_wr_addr, lut_wr_data,
      output prog_ctr, fetch_valid, busy, done
`ifdef FETCH_CYCLE_CNT_EN
      ,output cycle_cnt
`endif
   );

endinterface

// File: rtl/jump_lut.sv
// Jump-target table: 2**LUT_AW x PC_W registers, one sync write port, one comb read port.
// Reads see the pre-write contents, so a same-cycle write/read returns the old entry.
module jump_lut import fetch_pkg::*; #(
   parameter int LUT_AW = LUT_AW_DEF,
   parameter int PC_W   = PC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [LUT_AW-1:0] wr_addr,
   input  logic [PC_W-1:0]   wr_data,
   input  logic [LUT_AW-1:0] rd_addr,
   output logic [PC_W-1:0]   rd_data
);

   localparam int DEPTH = 1 << LUT_AW;

   logic [PC_W-1:0] mem_q [DEPTH];
   logic [PC_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer: IDLE/RUN/DONE FSM, PC update and jump LUT.
// Define FETCH_CYCLE_CNT_EN to add the saturating RUN-cycle counter (cycle_cnt).
module fetch_unit import fetch_pkg::*; #(
   parameter int PC_W       = PC_W_DEF,
   parameter int LUT_AW     = LUT_AW_DEF,
   parameter int START_ADDR = 0
`ifdef FETCH_CYCLE_CNT_EN
   ,parameter int CNT_W     = 16
`endif
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.slave  bus
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] lut_target;
   logic            busy;
   logic            run_entry;

   jump_lut #(
      .LUT_AW (LUT_AW),
      .PC_W   (PC_W)
   ) u_jump_lut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bus.lut_wr_en),
      .wr_addr (bus.lut_wr_addr),
      .wr_data (bus.lut_wr_data),
      .rd_addr (bus.lut_ptr),
      .rd_data (lut_target)
   );

   assign busy      = (state_q == FS_RUN);
   assign run_entry = (state_q != FS_RUN) && bus.start;

   // Priority inside RUN: stall > halt > jump > increment
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         FS_IDLE, FS_DONE: begin
            if (bus.start) begin
               state_d = FS_RUN;
               pc_d    = PC_W'(START_ADDR);
            end
         end
         FS_RUN: begin
            if (!bus.stall) begin
               if (bus.halt) begin
                  state_d = FS_DONE;
               end else if (bus.jmp_en) begin
                  pc_d = bus.jmp_abs ? lut_target : pc_q + bus.rel_off;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FS_IDLE;
         pc_q    <= PC_W'(START_ADDR);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.prog_ctr    = pc_q;
   assign bus.busy        = busy;
   assign bus.done        = (state_q == FS_DONE);
   assign bus.fetch_valid = busy & ~bus.stall;

`ifdef FETCH_CYCLE_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

   // Counts every RUN edge, stalled or not; holds in IDLE/DONE
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (run_entry) begin
         cycle_cnt_d = '0;
      end else if (busy && (cycle_cnt_q != '1)) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cycle_cnt_q <= '0;
      else        cycle_cnt_q <= cycle_cnt_d;
   end

   assign bus.cycle_cnt = cycle_cnt_q;
`else
   logic unused_run_entry;
   assign unused_run_entry = run_entry;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue/array model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int PC_W   = 10;
   localparam int LUT_AW = 4;
   localparam int N_PC   = 1 << PC_W;
   localparam int N_LUT  = 1 << LUT_AW;
`ifdef FETCH_CYCLE_CNT_EN
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fetch_unit_if #(
      .PC_W   (PC_W),
      .LUT_AW (LUT_AW)
`ifdef FETCH_CYCLE_CNT_EN
      ,.CNT_W (CNT_W)
`endif
   ) bus ();

   fetch_unit #(
      .PC_W       (PC_W),
      .LUT_AW     (LUT_AW),
      .START_ADDR (0)
`ifdef FETCH_CYCLE_CNT_EN
      ,.CNT_W     (CNT_W)
`endif
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int m_state;
   int m_pc;
   int m_lut [N_LUT];
   int m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE;
      m_pc    = 0;
      m_cnt   = 0;
      for (int i = 0; i < N_LUT; i++) m_lut[i] = 0;
   endtask

   // Applies one clock edge to the model using the inputs currently driven.
   task automatic model_edge();
      int next_pc;
      if (!rst_n) begin
         model_reset();
         return;
      end
      next_pc = m_pc;
      if (m_state == M_RUN) begin
         m_cnt = (m_cnt < 1000000) ? m_cnt + 1 : m_cnt;
         if (!bus.stall) begin
            if (bus.halt) m_state = M_DONE;
            else if (bus.jmp_en && bus.jmp_abs) next_pc = m_lut[bus.lut_ptr];
            else if (bus.jmp_en) next_pc = (m_pc + int'(bus.rel_off)) % N_PC;
            else next_pc = (m_pc + 1) % N_PC;
         end
      end else if (bus.start) begin
         m_state = M_RUN;
         next_pc = 0;
         m_cnt   = 0;
      end
      m_pc = next_pc;
      if (bus.lut_wr_en) m_lut[bus.lut_wr_addr] = int'(bus.lut_wr_data);
   endtask

   task automatic check_outputs();
      check("pc", 32'(bus.prog_ctr), 32'(m_pc));
      check("busy", 32'(bus.busy), 32'(m_state == M_RUN));
      check("done", 32'(bus.done), 32'(m_state == M_DONE));
      check("fetch_valid", 32'(bus.fetch_valid), 32'((m_state == M_RUN) && !bus.stall));
`ifdef FETCH_CYCLE_CNT_EN
      check("cycle_cnt", 32'(bus.cycle_cnt), 32'((m_cnt > CNT_MAX) ? CNT_MAX : m_cnt));
`endif
   endtask

   // Called 1 time unit after a rising edge with inputs already set.
   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.stall       = 1'b0;
      bus.halt        = 1'b0;
      bus.jmp_en      = 1'b0;
      bus.jmp_abs     = 1'b0;
      bus.lut_ptr     = '0;
      bus.rel_off     = '0;
      bus.lut_wr_en   = 1'b0;
      bus.lut_wr_addr = '0;
      bus.lut_wr_data = '0;
   endtask

   task automatic lut_write(input int addr, input int data);
      bus.lut_wr_en   = 1'b1;
      bus.lut_wr_addr = LUT_AW'(addr);
      bus.lut_wr_data = PC_W'(data);
      step();
      bus.lut_wr_en   = 1'b0;
   endtask

   task automatic jump_abs(input int ptr);
      bus.jmp_en  = 1'b1;
      bus.jmp_abs = 1'b1;
      bus.lut_ptr = LUT_AW'(ptr);
      step();
      bus.jmp_en  = 1'b0;
      bus.jmp_abs = 1'b0;
   endtask

   initial begin
      logic [PC_W-1:0] held_pc;
      idle_inputs();
      rst_n = 1'b0;
      model_reset();
      repeat (2) step();
      check("rst_pc", 32'(bus.prog_ctr), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      repeat (2) step();

      // Start, then sequential fetch from address 0
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("t1_pc0", 32'(bus.prog_ctr), 32'd0);
      check("t1_busy", 32'(bus.busy), 32'd1);
      repeat (3) step();
      check("t1_pc3", 32'(bus.prog_ctr), 32'd3);

      // Absolute jump through the LUT, then read-before-write on same entry
      lut_write(3, 'h1F0);
      step();
      check("t2_pc5", 32'(bus.prog_ctr), 32'd5);
      jump_abs(3);
      check("t2_abs", 32'(bus.prog_ctr), 32'h1F0);
      bus.lut_wr_en = 1'b1; bus.lut_wr_addr = 4'd3; bus.lut_wr_data = 10'h055;
      jump_abs(3);
      bus.lut_wr_en = 1'b0;
      check("t2_old_val", 32'(bus.prog_ctr), 32'h1F0);
      jump_abs(3);
      check("t2_new_val", 32'(bus.prog_ctr), 32'h055);

      // Relative jump with negative offset, then wrap on increment
      lut_write(1, 2);
      jump_abs(1);
      check("t3_pc2", 32'(bus.prog_ctr), 32'd2);
      bus.jmp_en = 1'b1; bus.jmp_abs = 1'b0; bus.rel_off = 10'h3FD;
      step();
      idle_inputs();
      check("t3_rel", 32'(bus.prog_ctr), 32'h3FF);
      step();
      check("t3_wrap", 32'(bus.prog_ctr), 32'h000);

      // Stall beats halt and jump
      held_pc = bus.prog_ctr;
      bus.stall = 1'b1; bus.halt = 1'b1; bus.jmp_en = 1'b1; bus.jmp_abs = 1'b1; bus.lut_ptr = 4'd3;
      repeat (2) step();
      #1;
      check("t4_fv", 32'(bus.fetch_valid), 32'd0);
      check("t4_hold", 32'(bus.prog_ctr), 32'(held_pc));
      check("t4_run", 32'(bus.busy), 32'd1);
      idle_inputs();
      @(posedge clk); model_edge(); #1;

      // Halt at PC 7, restart, start ignored while running
      lut_write(2, 7);
      jump_abs(2);
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      check("t5_done", 32'(bus.done), 32'd1);
      check("t5_pc7", 32'(bus.prog_ctr), 32'd7);
      repeat (2) step();
      bus.start = 1'b1;
      step();
      check("t5_restart", 32'(bus.prog_ctr), 32'd0);
      check("t5_busy", 32'(bus.busy), 32'd1);
      repeat (3) step();
      bus.start = 1'b0;
      check("t5_ign", 32'(bus.prog_ctr), 32'd3);

`ifdef FETCH_CYCLE_CNT_EN
      repeat (20) step();
      check("t6_sat", 32'(bus.cycle_cnt), 32'd15);
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      repeat (2) step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("t6_clr", 32'(bus.cycle_cnt), 32'd0);
`endif

      // Reset mid-run clears state and LUT
      lut_write(5, 'h123);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_rst_busy", 32'(bus.busy), 32'd0);
      check("t6_rst_pc", 32'(bus.prog_ctr), 32'd0);
      step();
      rst_n = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      jump_abs(5);
      check("t6_lut_clr", 32'(bus.prog_ctr), 32'd0);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         rst_n           = ($urandom_range(0, 249) != 0);
         if (!rst_n) begin
            model_reset();
         end
         bus.start       = ($urandom_range(0, 7) == 0);
         bus.stall       = ($urandom_range(0, 4) == 0);
         bus.halt        = ($urandom_range(0, 19) == 0);
         bus.jmp_en      = ($urandom_range(0, 3) == 0);
         bus.jmp_abs     = 1'($urandom);
         bus.lut_ptr     = LUT_AW'($urandom);
         bus.rel_off     = PC_W'($urandom);
         bus.lut_wr_en   = ($urandom_range(0, 2) == 0);
         bus.lut_wr_addr = LUT_AW'($urandom);
         bus.lut_wr_data = PC_W'($urandom);
         step();
      end
      rst_n = 1'b1;
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
